// File: rtl/gshare_predictor_param.sv
// Parametrised gshare direction predictor: combinational prediction in F,
// speculative global history with checkpoint repair, EX-stage training and
// saturating branch/mispredict statistics.
module gshare_predictor_param #(
   parameter int unsigned INDEX_BITS = 12,
   parameter int unsigned HIST_BITS  = 8,
   parameter int unsigned CTR_BITS   = 2,
   parameter int unsigned PC_LSB     = 2,
   parameter int unsigned STAT_BITS  = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 branch_en_F,
   input  logic                 stall_F,
   input  logic [31:0]          PC_F,
   output logic                 pred_taken_F,
   output logic [HIST_BITS-1:0] hist_F,
   input  logic                 branch_en_EX,
   input  logic [31:0]          PC_EX,
   input  logic [HIST_BITS-1:0] hist_EX,
   input  logic                 pred_taken_EX,
   input  logic                 taken_EX,
   output logic                 mispredict_EX,
   output logic [STAT_BITS-1:0] branch_count,
   output logic [STAT_BITS-1:0] mispredict_count
);

   localparam int unsigned DEPTH = 32'd1 << INDEX_BITS;
   localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((32'd1 << (CTR_BITS - 1)) - 32'd1);
   localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;

   // Reject parameter combinations the indexing scheme cannot support
   if ((HIST_BITS < 1) || (HIST_BITS > INDEX_BITS) || (CTR_BITS < 1) || (CTR_BITS > 4) ||
       ((PC_LSB + INDEX_BITS) > 32)) begin : g_param_check
      $error("gshare_predictor_param: illegal parameter combination");
   end

   logic [CTR_BITS-1:0]   pht [DEPTH];
   logic [HIST_BITS-1:0]  ghr;
   logic [HIST_BITS-1:0]  ghr_next;
   logic [INDEX_BITS-1:0] idx_f;
   logic [INDEX_BITS-1:0] idx_ex;
   logic [CTR_BITS-1:0]   ctr_f;
   logic [CTR_BITS-1:0]   ctr_ex;
   logic [CTR_BITS-1:0]   ctr_ex_next;
   logic                  unused_bits;

   // Only a slice of each PC (and the history MSB on shift-out) is consumed
   assign unused_bits = ^{PC_F, PC_EX, hist_EX};

   // Prediction is forced low while reset is held
   assign pred_taken_F  = rst & branch_en_F & ctr_f[CTR_BITS-1];
   assign hist_F        = ghr;
   assign mispredict_EX = branch_en_EX & (taken_EX != pred_taken_EX);

   // Index hashing, counter training value and next global history
   always_comb begin
      idx_f       = PC_F[PC_LSB +: INDEX_BITS] ^ INDEX_BITS'(ghr);
      idx_ex      = PC_EX[PC_LSB +: INDEX_BITS] ^ INDEX_BITS'(hist_EX);
      ctr_f       = pht[idx_f];
      ctr_ex      = pht[idx_ex];
      ctr_ex_next = ctr_ex;
      ghr_next    = ghr;
      if (taken_EX) begin
         if (ctr_ex != CTR_MAX) ctr_ex_next = ctr_ex + CTR_BITS'(1);
      end else begin
         if (ctr_ex != '0) ctr_ex_next = ctr_ex - CTR_BITS'(1);
      end
      // Repair wins: the F instruction in this cycle is being flushed
      if (mispredict_EX) begin
         ghr_next = HIST_BITS'({hist_EX, taken_EX});
      end else if (branch_en_F && !stall_F) begin
         ghr_next = HIST_BITS'({ghr, pred_taken_F});
      end
   end

   // Pattern table: weakly not-taken on reset, trained by resolved EX branches
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            pht[INDEX_BITS'(i)] <= CTR_INIT;
         end
      end else if (branch_en_EX) begin
         pht[idx_ex] <= ctr_ex_next;
      end
   end

   // Global history and saturating statistics
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ghr              <= '0;
         branch_count     <= '0;
         mispredict_count <= '0;
      end else begin
         ghr <= ghr_next;
         if (branch_en_EX && (branch_count != '1)) begin
            branch_count <= branch_count + STAT_BITS'(1);
         end
         if (mispredict_EX && (mispredict_count != '1)) begin
            mispredict_count <= mispredict_count + STAT_BITS'(1);
         end
      end
   end

endmodule

// File: tb/tb_gshare_predictor_param.sv
// Bench for gshare_predictor_param: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_gshare_predictor_param;

   logic        clk;
   logic        rst;
   logic        bef, stall, ptf, beex, pex, tex, mex;
   logic [31:0] pcf, pcex;
   logic [7:0]  histf, histex;
   logic [31:0] bc, mc;

   logic        s_rst, s_bef, s_stall, s_ptf, s_beex, s_pex, s_tex, s_mex;
   logic [31:0] s_pcf, s_pcex;
   logic        s_histf, s_histex;
   logic [3:0]  s_bc, s_mc;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_on = 0;

   gshare_predictor_param dut (
      .clk(clk), .rst(rst), .branch_en_F(bef), .stall_F(stall), .PC_F(pcf),
      .pred_taken_F(ptf), .hist_F(histf), .branch_en_EX(beex), .PC_EX(pcex),
      .hist_EX(histex), .pred_taken_EX(pex), .taken_EX(tex), .mispredict_EX(mex),
      .branch_count(bc), .mispredict_count(mc)
   );

   gshare_predictor_param #(.INDEX_BITS(4), .HIST_BITS(1), .CTR_BITS(1), .PC_LSB(2), .STAT_BITS(4)) dut_small (
      .clk(clk), .rst(s_rst), .branch_en_F(s_bef), .stall_F(s_stall), .PC_F(s_pcf),
      .pred_taken_F(s_ptf), .hist_F(s_histf), .branch_en_EX(s_beex), .PC_EX(s_pcex),
      .hist_EX(s_histex), .pred_taken_EX(s_pex), .taken_EX(s_tex), .mispredict_EX(s_mex),
      .branch_count(s_bc), .mispredict_count(s_mc)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- behavioural model (default parameters) ----------------
   int unsigned     m_pht [4096];
   int unsigned     m_ghr;
   longint unsigned m_bc, m_mc;

   function automatic int unsigned m_idx(logic [31:0] pc, int unsigned h);
      return ((int'(pc) >>> 0) >> 2) % 4096 ^ h;
   endfunction

   function automatic bit exp_pred();
      return rst && bef && (m_pht[m_idx(pcf, m_ghr)] >= 2);
   endfunction

   always @(posedge clk or negedge rst) begin : model
      bit pf, mp;
      int unsigned k;
      if (!rst) begin
         for (int i = 0; i < 4096; i++) m_pht[i] = 1;
         m_ghr = 0;
         m_bc  = 0;
         m_mc  = 0;
      end else begin
         pf = exp_pred();
         mp = beex && (tex != pex);
         if (beex) begin
            k = m_idx(pcex, histex);
            if (tex && m_pht[k] < 3) m_pht[k] = m_pht[k] + 1;
            if (!tex && m_pht[k] > 0) m_pht[k] = m_pht[k] - 1;
            if (m_bc < 64'hFFFF_FFFF) m_bc++;
         end
         if (mp && m_mc < 64'hFFFF_FFFF) m_mc++;
         if (mp) m_ghr = (int'(histex) * 2 + int'(tex)) % 256;
         else if (bef && !stall) m_ghr = (m_ghr * 2 + int'(pf)) % 256;
      end
   end

   task automatic cmp(string name, longint unsigned act, longint unsigned exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model
   always @(negedge clk) begin
      if (chk_on) begin
         cmp("pred_taken_F", ptf, exp_pred());
         cmp("hist_F", histf, m_ghr);
         cmp("mispredict_EX", mex, beex && (tex != pex));
         cmp("branch_count", bc, m_bc);
         cmp("mispredict_count", mc, m_mc);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_main();
      bef = 0; stall = 0; pcf = 0; beex = 0; pcex = 0; histex = 0; pex = 0; tex = 0;
   endtask

   task automatic do_reset();
      idle_main();
      rst = 0;
      tick();
      rst = 1;
   endtask

   task automatic ex_drive(logic [31:0] pc, logic [7:0] h, logic t, logic p);
      beex = 1; pcex = pc; histex = h; tex = t; pex = p;
   endtask

   initial begin
      idle_main();
      s_bef = 0; s_stall = 0; s_pcf = 0; s_beex = 0; s_pcex = 0; s_histex = 0; s_pex = 0; s_tex = 0;
      rst = 1; s_rst = 1;
      #2;
      rst = 0; s_rst = 0;
      bef = 1; pcf = 32'h100;
      chk_on = 1;
      #1;
      cmp("rst_pred", ptf, 0);
      cmp("rst_hist", histf, 8'h00);
      cmp("rst_bc", bc, 0);
      cmp("rst_mc", mc, 0);
      tick();
      rst = 1; s_rst = 1;
      tick();
      cmp("post_rst_pred", ptf, 0);

      // Training to saturation and back
      stall = 1;
      ex_drive(32'h100, 8'h00, 1, 1);
      tick(); cmp("train1_pred", ptf, 1);
      tick(); tick(); cmp("train3_pred", ptf, 1);
      cmp("train3_bc", bc, 3);
      tex = 0; pex = 0;
      tick(); cmp("nt1_pred", ptf, 1);
      tick(); cmp("nt2_pred", ptf, 0);

      // Speculative history
      do_reset();
      foreach (m_pht[i]) if (i < 0) m_pht[i] = 0;
      for (int g = 0; g < 8; g++) begin
         if (g == 0 || g == 1 || g == 3 || g == 7) begin
            ex_drive(32'((32'h40 ^ g) << 2), 8'h00, 1, 1);
            tick();
         end
      end
      beex = 0;
      bef = 1; stall = 0; pcf = 32'h100;
      repeat (4) tick();
      cmp("spec4_hist", histf, 8'h0F);
      bef = 0;
      ex_drive(32'h3000, 8'h00, 0, 1);
      tick();
      beex = 0;
      cmp("spec_clear_hist", histf, 8'h00);
      bef = 1; pcf = 32'h100;
      tick();
      stall = 1; tick();
      stall = 0; tick(); tick();
      cmp("spec_stall_hist", histf, 8'h07);

      // Repair priority
      do_reset();
      ex_drive(32'h100, 8'h00, 1, 1);
      tick();
      ex_drive(32'h3000, 8'h55, 0, 1);
      tick();
      beex = 0;
      cmp("setup_hist_aa", histf, 8'hAA);
      cmp("setup_mc", mc, 1);
      bef = 1; stall = 0; pcf = 32'h3A8;
      ex_drive(32'h3000, 8'h35, 0, 1);
      #1;
      cmp("repair_pred_f", ptf, 1);
      cmp("repair_mispredict", mex, 1);
      tick();
      idle_main();
      cmp("repair_hist", histf, 8'h6A);
      cmp("repair_mc", mc, 2);

      // Same-index collision: F reads old counter during EX write
      do_reset();
      ex_drive(32'h3000, 8'h01, 0, 1);
      tick();
      bef = 1; stall = 1; pcf = 32'h8;
      ex_drive(32'h0, 8'h00, 1, 1);
      #1;
      cmp("collide_old", ptf, 0);
      tick();
      beex = 0;
      cmp("collide_new", ptf, 1);
      idle_main();

      // Small configuration: 1-bit counters, 1-bit history, 4-bit stats
      s_bef = 1; s_stall = 1; s_pcf = 0;
      s_beex = 1; s_pcex = 0; s_histex = 0;
      for (int i = 0; i < 6; i++) begin
         s_tex = ((i % 2) == 0);
         s_pex = s_tex;
         tick();
         cmp("small_toggle", s_ptf, ((i % 2) == 0));
      end
      repeat (14) tick();
      cmp("small_bc_sat", s_bc, 4'hF);
      s_tex = 1; s_pex = 0; s_histex = 0;
      tick();
      s_beex = 0;
      cmp("small_repair_hist", s_histf, 1);
      cmp("small_mc", s_mc, 1);
      tick();
      cmp("small_bc_hold", s_bc, 4'hF);

      // Randomized traffic, with occasional mid-cycle reset
      for (int c = 0; c < 3000; c++) begin
         if (!rst) rst = 1;
         else if ($urandom_range(0, 399) == 0) rst = 0;
         bef    = $urandom_range(0, 1);
         stall  = ($urandom_range(0, 3) == 0);
         pcf    = 32'(($urandom_range(0, 31) << 2) | ($urandom_range(0, 1) << 20));
         beex   = $urandom_range(0, 1);
         pcex   = 32'(($urandom_range(0, 31) << 2) | ($urandom_range(0, 1) << 20));
         histex = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 3));
         tex    = $urandom_range(0, 1);
         pex    = ($urandom_range(0, 3) == 0) ? ~tex : tex;
         tick();
      end
      rst = 1;
      idle_main();
      tick();
      tick();
      chk_on = 0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
